// File: rtl/mwfifo_pkg.sv
// Shared geometry helpers for the mixed-width FIFO: lane width, width ratio and
// capacity in lanes, all evaluated at elaboration time.
package mwfifo_pkg;

   function automatic int unsigned lane_width(input int unsigned wd, input int unsigned rd);
      return (wd < rd) ? wd : rd;
   endfunction

   function automatic int unsigned ratio(input int unsigned wd, input int unsigned rd);
      return ((wd > rd) ? wd : rd) / lane_width(wd, rd);
   endfunction

   function automatic int unsigned capacity(input int unsigned aw, input int unsigned wd,
                                            input int unsigned rd);
      return (32'd1 << aw) * wd / lane_width(wd, rd);
   endfunction

   function automatic bit is_pow2(input int unsigned x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

endpackage

// File: rtl/mwfifo_lane_mem.sv
// Lane storage for mwfifo: R banks of lane-wide words, each with its own write
// enable; all banks share one write row and one asynchronously read row.
module mwfifo_lane_mem
   import mwfifo_pkg::*;
#(
   parameter int unsigned LW = 8,
   parameter int unsigned R  = 4,
   parameter int unsigned RW = 2
) (
   input  logic                  clk,
   input  logic [R-1:0]          bank_we,
   input  logic [RW-1:0]         wr_row,
   input  logic [R-1:0][LW-1:0]  bank_wdata,
   input  logic [RW-1:0]         rd_row,
   output logic [R-1:0][LW-1:0]  bank_rdata
);

   for (genvar b = 0; b < R; b++) begin : g_bank
      logic [LW-1:0] bank_q [2**RW];

      always_ff @(posedge clk) begin
         if (bank_we[b]) bank_q[wr_row] <= bank_wdata[b];
      end

      assign bank_rdata[b] = bank_q[rd_row];
   end

endmodule

// File: rtl/mwfifo.sv
// Mixed-width first-word-fall-through FIFO with lane-granular occupancy.
// Optional registered almost-full/almost-empty flags: define MWFIFO_ALMOST_FLAGS_EN.
module mwfifo
   import mwfifo_pkg::*;
#(
   parameter int unsigned WDWIDTH    = 32,
   parameter int unsigned RDWIDTH    = 8,
   parameter int unsigned WAWIDTH    = 4,
   parameter int unsigned AFULL_LVL  = 12,
   parameter int unsigned AEMPTY_LVL = 2
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             flush,
   input  logic                                             wr_valid,
   output logic                                             wr_ready,
   input  logic [WDWIDTH-1:0]                               wr_data,
   output logic                                             rd_valid,
   input  logic                                             rd_ready,
   output logic [RDWIDTH-1:0]                               rd_data,
   output logic [WAWIDTH+$clog2(ratio(WDWIDTH, RDWIDTH)):0] level,
   output logic                                             almost_full,
   output logic                                             almost_empty
);

   localparam int unsigned LW    = lane_width(WDWIDTH, RDWIDTH);
   localparam int unsigned R     = ratio(WDWIDTH, RDWIDTH);
   localparam int unsigned LOG2R = $clog2(R);
   localparam int unsigned CAP   = capacity(WAWIDTH, WDWIDTH, RDWIDTH);
   localparam int unsigned WL    = WDWIDTH / LW;
   localparam int unsigned RL    = RDWIDTH / LW;
   localparam int unsigned PW    = $clog2(CAP);
   localparam int unsigned LVW   = WAWIDTH + LOG2R + 1;
   localparam int unsigned ROWS  = CAP / R;
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned BW    = (R > 1) ? LOG2R : 1;

   if (!is_pow2(R)) begin : g_bad_ratio
      $error("mwfifo: width ratio must be 1 or a power of two");
   end
   if (AEMPTY_LVL >= AFULL_LVL) begin : g_bad_lvl
      $error("mwfifo: AEMPTY_LVL must be below AFULL_LVL");
   end

   logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
   logic [LVW-1:0]         level_q, level_d;
   logic                   wr_acc, rd_acc;
   logic [R-1:0]           bank_we;
   logic [R-1:0][LW-1:0]   bank_wdata, bank_rdata;
   logic [RW-1:0]          wr_row, rd_row;
   logic [RDWIDTH-1:0]     rd_word;

   assign wr_ready = (level_q <= LVW'(CAP - WL)) && !flush;
   assign rd_valid = (level_q >= LVW'(RL));
   assign wr_acc   = wr_valid && wr_ready;
   assign rd_acc   = rd_valid && rd_ready && !flush;
   assign level    = level_q;

   // Lane pointers count lanes; the row is the lane index with the bank bits dropped.
   assign wr_row = RW'(32'(wp_q) / R);
   assign rd_row = RW'(32'(rp_q) / R);

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      level_d = level_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         level_d = '0;
      end else begin
         if (wr_acc) wp_d = wp_q + PW'(WL);
         if (rd_acc) rp_d = rp_q + PW'(RL);
         level_d = level_q + (wr_acc ? LVW'(WL) : '0) - (rd_acc ? LVW'(RL) : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
      end
   end

   if (WDWIDTH >= RDWIDTH) begin : g_wide_wr
      // A write fills every bank of one row; a read picks one lane.
      logic [BW-1:0] rd_bank;
      assign bank_we    = {R{wr_acc}};
      assign bank_wdata = wr_data;
      assign rd_bank    = BW'(32'(rp_q) % R);
      assign rd_word    = bank_rdata[rd_bank];
   end else begin : g_narrow_wr
      // A write fills one bank; a read returns the whole row, lane 0 in the LSBs.
      logic [BW-1:0] wr_bank;
      assign wr_bank    = BW'(32'(wp_q) % R);
      assign bank_we    = wr_acc ? (R'(1) << wr_bank) : '0;
      assign bank_wdata = {R{wr_data}};
      assign rd_word    = bank_rdata;
   end

   assign rd_data = rd_valid ? rd_word : '0;

   mwfifo_lane_mem #(
      .LW (LW),
      .R  (R),
      .RW (RW)
   ) u_lane_mem (
      .clk        (clk),
      .bank_we    (bank_we),
      .wr_row     (wr_row),
      .bank_wdata (bank_wdata),
      .rd_row     (rd_row),
      .bank_rdata (bank_rdata)
   );

`ifdef MWFIFO_ALMOST_FLAGS_EN
   logic af_q, ae_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (32'(level_d) >= AFULL_LVL);
         ae_q <= (32'(level_d) <= AEMPTY_LVL);
      end
   end

   assign almost_full  = af_q;
   assign almost_empty = ae_q;
`else
   assign almost_full  = 1'b0;
   assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_mwfifo.sv
// Bench for mwfifo: a 32->8 and an 8->32 instance checked every cycle against a
// lane-queue model, plus directed sequences with hand-computed expectations.
module tb_mwfifo;

`ifdef MWFIFO_ALMOST_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fl [2];
   logic        wv [2];
   logic        rr [2];
   logic [31:0] wd0;
   logic [7:0]  wd1;
   logic        wrdy [2];
   logic        rv [2];
   logic        af [2];
   logic        ae [2];
   logic [4:0]  lvl [2];
   logic [7:0]  rd0;
   logic [31:0] rd1;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: each FIFO is a plain queue of byte lanes.
   logic [7:0] lane [2][16];
   int         head [2];
   int         cnt  [2];

   logic [7:0] b036 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   always #5 clk = ~clk;

   mwfifo #(.WDWIDTH(32), .RDWIDTH(8), .WAWIDTH(2)) u_d0 (
      .clk(clk), .rst_n(rst_n), .flush(fl[0]),
      .wr_valid(wv[0]), .wr_ready(wrdy[0]), .wr_data(wd0),
      .rd_valid(rv[0]), .rd_ready(rr[0]), .rd_data(rd0),
      .level(lvl[0]), .almost_full(af[0]), .almost_empty(ae[0])
   );

   mwfifo #(.WDWIDTH(8), .RDWIDTH(32), .WAWIDTH(2)) u_d1 (
      .clk(clk), .rst_n(rst_n), .flush(fl[1]),
      .wr_valid(wv[1]), .wr_ready(wrdy[1]), .wr_data(wd1),
      .rd_valid(rv[1]), .rd_ready(rr[1]), .rd_data(rd1),
      .level(lvl[1]), .almost_full(af[1]), .almost_empty(ae[1])
   );

   function automatic int wl_of(int i);  return (i == 0) ? 4 : 1;  endfunction
   function automatic int rl_of(int i);  return (i == 0) ? 1 : 4;  endfunction
   function automatic int cap_of(int i); return (i == 0) ? 16 : 4; endfunction

   function automatic logic [31:0] exp_rd(int i);
      logic [31:0] v = '0;
      if (cnt[i] >= rl_of(i))
         for (int j = 0; j < rl_of(i); j++) v[8*j +: 8] = lane[i][(head[i] + j) % 16];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         cnt[i]  = 0;
         head[i] = 0;
      end
   endtask

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         fl[i] = 1'b0;
         wv[i] = 1'b0;
         rr[i] = 1'b0;
      end
      wd0 = '0;
      wd1 = '0;
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         logic [31:0] act_rd = (i == 0) ? {24'h0, rd0} : rd1;
         bit e_wr = (cap_of(i) - cnt[i] >= wl_of(i)) && !fl[i];
         chk($sformatf("d%0d level", i), 32'(lvl[i]), 32'(cnt[i]));
         chk($sformatf("d%0d wr_ready", i), 32'(wrdy[i]), 32'(e_wr));
         chk($sformatf("d%0d rd_valid", i), 32'(rv[i]), 32'(cnt[i] >= rl_of(i)));
         chk($sformatf("d%0d rd_data", i), act_rd, exp_rd(i));
         chk($sformatf("d%0d almost_full", i), 32'(af[i]), 32'(FLAGS && cnt[i] >= 12));
         chk($sformatf("d%0d almost_empty", i), 32'(ae[i]), 32'(FLAGS && cnt[i] <= 2));
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         logic [31:0] d   = (i == 0) ? wd0 : {24'h0, wd1};
         bit          wok = (cap_of(i) - cnt[i] >= wl_of(i)) && !fl[i];
         bit          rok = cnt[i] >= rl_of(i);
         if (fl[i]) begin
            cnt[i]  = 0;
            head[i] = 0;
         end else begin
            if (rok && rr[i]) begin
               head[i] = (head[i] + rl_of(i)) % 16;
               cnt[i]  = cnt[i] - rl_of(i);
            end
            if (wok && wv[i]) begin
               for (int j = 0; j < wl_of(i); j++) begin
                  lane[i][(head[i] + cnt[i]) % 16] = d[8*j +: 8];
                  cnt[i]++;
               end
            end
         end
      end
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic settle();
      idle();
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset level", 32'(lvl[i]), 32'd0);
         chk("reset rd_valid", 32'(rv[i]), 32'd0);
         chk("reset wr_ready", 32'(wrdy[i]), 32'd1);
         chk("reset almost_full", 32'(af[i]), 32'd0);
         chk("reset almost_empty", 32'(ae[i]), 32'(FLAGS));
      end
      chk("reset rd_data d0", {24'h0, rd0}, 32'd0);
      chk("reset rd_data d1", rd1, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Asynchronous reset in the middle of traffic
      wv[0] = 1'b1; wd0 = 32'hdeadbeef; wv[1] = 1'b1; wd1 = 8'haa;
      tick();
      idle(); wv[1] = 1'b1; wd1 = 8'hbb;
      tick();
      settle();
      chk("pre-reset d0 level", 32'(lvl[0]), 32'd4);
      chk("pre-reset d1 level", 32'(lvl[1]), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("async reset d0 level", 32'(lvl[0]), 32'd0);
      chk("async reset d0 rd_valid", 32'(rv[0]), 32'd0);
      chk("async reset d0 wr_ready", 32'(wrdy[0]), 32'd1);
      chk("async reset d1 level", 32'(lvl[1]), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;

      // Wide write, four narrow reads in little-endian lane order
      wv[0] = 1'b1; wd0 = 32'h44332211;
      tick();
      settle();
      chk("036 rd_valid", 32'(rv[0]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("036 read %0d", k), {24'h0, rd0}, {24'h0, b036[k]});
         rr[0] = 1'b1;
         tick();
         settle();
      end
      chk("036 level after", 32'(lvl[0]), 32'd0);

      // Fill, drain to the write threshold, then write+read across the wrap
      for (int k = 0; k < 4; k++) begin
         wv[0] = 1'b1;
         wd0   = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
         tick();
      end
      settle();
      chk("037 full level", 32'(lvl[0]), 32'd16);
      chk("037 full wr_ready", 32'(wrdy[0]), 32'd0);
      rr[0] = 1'b1;
      tick();
      settle();
      chk("037 level 15", 32'(lvl[0]), 32'd15);
      chk("037 wr_ready at 15", 32'(wrdy[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         rr[0] = 1'b1;
         tick();
      end
      settle();
      chk("037 level 12", 32'(lvl[0]), 32'd12);
      chk("037 wr_ready at 12", 32'(wrdy[0]), 32'd1);
      chk("038 head lane", {24'h0, rd0}, 32'h04);
      wv[0] = 1'b1; wd0 = 32'h13121110; rr[0] = 1'b1;
      tick();
      settle();
      chk("038 level 15", 32'(lvl[0]), 32'd15);
      chk("038 next lane", {24'h0, rd0}, 32'h05);
      for (int k = 0; k < 15; k++) begin
         rr[0] = 1'b1;
         tick();
      end
      settle();
      chk("038 drained", 32'(lvl[0]), 32'd0);

      // Narrow writes assemble one wide read word
      for (int k = 1; k <= 3; k++) begin
         wv[1] = 1'b1; wd1 = 8'(8'h11 * k);
         tick();
         settle();
         chk($sformatf("039 rd_valid after %0d", k), 32'(rv[1]), 32'd0);
      end
      wv[1] = 1'b1; wd1 = 8'h44;
      tick();
      settle();
      chk("039 rd_valid", 32'(rv[1]), 32'd1);
      chk("039 rd_data", rd1, 32'h44332211);
      rr[1] = 1'b1;
      tick();
      settle();
      chk("039 level after", 32'(lvl[1]), 32'd0);

`ifdef MWFIFO_ALMOST_FLAGS_EN
      wv[0] = 1'b1; wd0 = 32'h01020304;
      tick();
      idle(); rr[0] = 1'b1;
      tick();
      settle();
      chk("040 lvl3 almost_empty", 32'(ae[0]), 32'd0);
      chk("040 lvl3 almost_full", 32'(af[0]), 32'd0);
      rr[0] = 1'b1;
      tick();
      settle();
      chk("040 lvl2 almost_empty", 32'(ae[0]), 32'd1);
      chk("040 lvl2 almost_full", 32'(af[0]), 32'd0);
      for (int k = 0; k < 2; k++) begin
         rr[0] = 1'b1;
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         wv[0] = 1'b1; wd0 = $urandom;
         tick();
      end
      settle();
      chk("040 lvl12 almost_full", 32'(af[0]), 32'd1);
      chk("040 lvl12 almost_empty", 32'(ae[0]), 32'd0);
      fl[0] = 1'b1; wv[0] = 1'b1; rr[0] = 1'b1;
      tick();
      settle();
      chk("040 flush level", 32'(lvl[0]), 32'd0);
      chk("040 flush almost_empty", 32'(ae[0]), 32'd1);
`endif

      // Randomized traffic on both instances, including occasional flush
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            wv[i] = ($urandom_range(0, 3) != 0);
            rr[i] = ($urandom_range(0, 3) != 0);
            fl[i] = ($urandom_range(0, 63) == 0);
         end
         wd0 = $urandom;
         wd1 = 8'($urandom);
         tick();
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
